// File: rtl/restoring_division_v2.sv
// Sequential restoring divider: one quotient bit per cycle, valid/ready handshakes on both sides.
// Define RESTORING_DIVISION_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module restoring_division_v2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             valid_in,
    output logic             ready_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic [WIDTH-1:0] acc, q, m;
    logic [CW-1:0]    cnt;
    logic             dz;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, res_q, res_r;

    // acc never exceeds the divisor after a step, so WIDTH bits hold it; the
    // extra bit lives only in the trial subtraction where the sign is decided.
    assign shifted = {acc, q[WIDTH-1]};
    assign diff    = shifted - {1'b0, m};

`ifdef RESTORING_DIVISION_SIGNED_EN
    logic q_neg, r_neg;
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Zero-divisor results bypass the sign fix-up: -1 and the raw dividend.
    assign res_q   = (q_neg && !dz) ? -q   : q;
    assign res_r   = (r_neg && !dz) ? -acc : acc;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign res_q   = q;
    assign res_r   = acc;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ready_in    <= 1'b1;
            valid_out   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            q           <= '0;
            m           <= '0;
            dz          <= 1'b0;
`ifdef RESTORING_DIVISION_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        cnt      <= '0;
                        ready_in <= 1'b0;
                        m        <= dvs_mag;
`ifdef RESTORING_DIVISION_SIGNED_EN
                        q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg    <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            dz    <= 1'b1;
                            acc   <= dividend;
                            q     <= '1;
                            state <= DONE;
                        end else begin
                            dz    <= 1'b0;
                            acc   <= '0;
                            q     <= dvd_mag;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (diff[WIDTH]) begin
                        acc <= shifted[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= diff[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the result; valid_out follows one edge later.
                    if (!valid_out) begin
                        valid_out   <= 1'b1;
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= dz;
                    end else if (ready_out) begin
                        valid_out <= 1'b0;
                        ready_in  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_division_v2.sv
// Directed bench for restoring_division_v2 (WIDTH=8): driver pushes expected results,
// a negedge monitor pops and compares on every valid_out/ready_out handshake.
module tb_restoring_division_v2;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         valid_in = 1'b0, ready_out = 1'b1;
    logic         ready_in, valid_out, div_by_zero;
    logic [W-1:0] quotient, remainder;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    restoring_division_v2 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
        .valid_in(valid_in), .ready_in(ready_in), .valid_out(valid_out),
        .ready_out(ready_out), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake is about to happen at the next rising edge.
    always @(negedge clk) begin
        if (reset && valid_out && ready_out) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_result: got q=%0h r=%0h, expected no result", quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dz);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready_in && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_in) check("ready_in_timeout", ready_in, 1);
    endtask

    task automatic run_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                           input int elat, input bit hold_vin, input int bp);
        int lat;
        exp_t e;
        wait_ready();
        dividend  = dvd;
        divisor   = dvs;
        valid_in  = 1'b1;
        ready_out = (bp == 0);
        @(posedge clk); #1;
        e.q = eq; e.r = er; e.dz = edz;
        sb.push_back(e);
        if (!hold_vin) valid_in = 1'b0;
        dividend = W'($urandom_range(1, 255));
        divisor  = W'($urandom_range(1, 255));
        lat = 0;
        while (!valid_out && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, elat);
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                check("bp_valid", valid_out, 1);
                check("bp_quotient", quotient, eq);
                check("bp_remainder", remainder, er);
                @(posedge clk); #1;
            end
            ready_out = 1'b1;
        end
        @(posedge clk); #1;
        check("ready_in_after_done", ready_in, 1);
        check("valid_out_after_done", valid_out, 0);
        valid_in = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready_in", ready_in, 1);
        check("rst_valid_out", valid_out, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        reset = 1'b1;
        @(posedge clk); #1;

`ifdef RESTORING_DIVISION_SIGNED_EN
        run_div(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, W + 1, 1'b0, 0); // -100 / 7
        run_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, W + 1, 1'b0, 0); // -128 / -1
        run_div(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, W + 1, 1'b0, 0); // 100 / -7
        run_div(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, W + 1, 1'b0, 0); // -100 / -7
        run_div(8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, W + 1, 1'b1, 0); // 127 / -128
        run_div(8'h85, 8'h00, 8'hFF, 8'h85, 1'b1, 1,     1'b0, 0); // zero divisor
        run_div(8'h64, 8'h09, 8'h0B, 8'h01, 1'b0, W + 1, 1'b0, 5); // 100 / 9, backpressure
`else
        run_div(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, W + 1, 1'b0, 0);
        run_div(8'h55,  8'd0,   8'hFF,  8'h55, 1'b1, 1,     1'b0, 0);
        run_div(8'd200, 8'd9,   8'd22,  8'd2,  1'b0, W + 1, 1'b0, 5);
        run_div(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, W + 1, 1'b0, 0);
        run_div(8'd7,   8'd200, 8'd0,   8'd7,  1'b0, W + 1, 1'b0, 0);
        run_div(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, W + 1, 1'b0, 0);
        run_div(8'd0,   8'd5,   8'd0,   8'd0,  1'b0, W + 1, 1'b0, 0);
        run_div(8'd128, 8'd16,  8'd8,   8'd0,  1'b0, W + 1, 1'b1, 0);
`endif
        // Zero divisor result must not leak div_by_zero into the next one.
        run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, W + 1, 1'b0, 0);

        // Reset at edge 4 of 255/3: result discarded.
        wait_ready();
        dividend = 8'd255;
        divisor  = 8'd3;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("midrst_ready_in", ready_in, 1);
        check("midrst_valid_out", valid_out, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_div_by_zero", div_by_zero, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
        check("midrst_no_valid", seen, 0);

        run_div(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, W + 1, 1'b0, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/restoring_division_v2.md
RESTORING_DIVISION_V2 -- requirements
Module: restoring_division_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-004 SHALL have port dividend, input, WIDTH, dividend operand.
REQ-005 SHALL have port divisor, input, WIDTH, divisor operand.
REQ-006 SHALL have port valid_in, input, 1, operands valid.
REQ-007 SHALL have port ready_in, output, 1, divider can accept operands.
REQ-008 SHALL have port valid_out, output, 1, result valid.
REQ-009 SHALL have port ready_out, input, 1, consumer accepts result.
REQ-010 SHALL have port quotient, output, WIDTH, quotient result.
REQ-011 SHALL have port remainder, output, WIDTH, remainder result.
REQ-012 SHALL have port div_by_zero, output, 1, result came from a zero divisor.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-014 ready_in SHALL be 1 only in IDLE; valid_out SHALL be 1 only in DONE.
REQ-015 Accept = valid_in && ready_in at an edge: operands captured, iteration counter cleared, IDLE -> BUSY.
REQ-016 Operand changes after acceptance SHALL have no effect on the result in flight.
REQ-017 BUSY SHALL perform one restoring iteration per cycle: shift {A,Q} left by 1, A = A - M on a (WIDTH+1)-bit accumulator; if A negative, restore A and set Q[0]=0, else set Q[0]=1.
REQ-018 BUSY -> DONE after exactly WIDTH iterations; valid_out SHALL rise WIDTH+1 edges after the accepting edge (counting from the accepting edge itself as edge 0: edges 1..WIDTH perform iterations).
REQ-019 Divisor == 0 at acceptance: IDLE -> DONE directly; quotient = all ones, remainder = dividend, div_by_zero = 1; valid_out rises 1 edge after the accepting edge.
REQ-020 div_by_zero SHALL be 0 for every result with a non-zero divisor.
REQ-021 In DONE, quotient, remainder, div_by_zero SHALL hold stable while ready_out = 0 (backpressure, unbounded).
REQ-022 DONE && ready_out at an edge: DONE -> IDLE; ready_in = 1 from the next cycle; no new operand is accepted in the same edge.
REQ-023 valid_in while not in IDLE SHALL be ignored; operands are not queued.
REQ-024 quotient and remainder SHALL retain the last result in IDLE and BUSY until the next result is produced.

Reset
REQ-025 reset = 0 at an edge SHALL force IDLE, ready_in = 1 on the following cycle, valid_out = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0.
REQ-026 Reset in BUSY or DONE SHALL discard the in-flight result; no valid_out pulse for it afterwards.
REQ-027 Reset SHALL take priority over acceptance and over the ready_out handshake at the same edge.

Configuration
REQ-028 Macro RESTORING_DIVISION_SIGNED_EN defined: operands and results SHALL be two's complement; magnitudes divided per REQ-017, quotient negated when operand signs differ, remainder takes the dividend's sign; latency unchanged.
REQ-029 With RESTORING_DIVISION_SIGNED_EN: most-negative / -1 SHALL give quotient = most-negative (wrap), remainder = 0, div_by_zero = 0; zero divisor SHALL give quotient = all ones (-1), remainder = dividend.
REQ-030 Macro undefined: operands and results SHALL be unsigned; no sign-correction logic present.

Verification (WIDTH = 8)
REQ-031 Unsigned: dividend = 100, divisor = 7 accepted at edge 0 -> valid_out at edge 9, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-032 Zero divisor: dividend = 0x55, divisor = 0 -> valid_out at edge 1, quotient = 0xFF, remainder = 0x55, div_by_zero = 1.
REQ-033 Backpressure: 200/9 with ready_out = 0 for 5 cycles after valid_out -> quotient = 22, remainder = 2 held stable; IDLE and ready_in = 1 on the cycle after ready_out = 1.
REQ-034 Reset mid-operation: reset = 0 at edge 4 of a 255/3 division -> all outputs 0, ready_in = 1; no valid_out for 20 cycles.
REQ-035 Signed (macro defined): -100/7 -> quotient = 0xF2, remainder = 0xFE; -128/-1 -> quotient = 0x80, remainder = 0.
